fp16_to_fixed_stream: RTL

Streaming converter from IEEE-754 binary16 (the spatial-array adder's output format: sign[15], exponent[14:10] bias 15, fraction[9:0]) back to signed two's-complement fixed point. It decodes the format and unpacks FP16 results for the integer accumulation and readout paths. It is a 2-stage valid/ready pipeline with full backpressure, truncation toward zero, saturation, and a saturation event counter.

---
 rtl/fp16_to_fixed_stream.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/fp16_to_fixed_stream.sv
// fp16_to_fixed_stream
//
// Converts a stream of IEEE-754 binary16 words, such as the outputs of the
// spatial-array adder, into signed two's-complement fixed point. The fixed
// point result has OUT_W bits, and FRAC_W of them are fractional.
//
// The converter is a 2-stage valid/ready pipeline with full backpressure.
// - Stage 1 decodes the word and aligns the mantissa into a magnitude.
// - Stage 2 applies the sign, clamps out-of-range values and resolves Inf/NaN.
// Results are truncated toward zero. A 16-bit saturating counter tallies
// every delivered result that was clamped or came from Inf/NaN.
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   rst_ni       synchronous active-low reset
//   in_valid_i   upstream word valid
//   in_ready_o   converter accepts in_data_i this cycle
//   in_data_i    binary16 operand
//   out_valid_o  result valid
//   out_ready_i  downstream accepts the result
//   out_data_o   fixed-point result (OUT_W bits, signed)
//   out_sat_o    result was clamped, or the input was Inf/NaN
//   sat_count_o  saturating count of delivered results with out_sat_o=1
//   clr_count_i  synchronous clear of sat_count_o (wins over an increment)

module fp16_to_fixed_stream #(
  parameter int OUT_W  = 24,
  parameter int FRAC_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [15:0]      in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_sat_o,
  output logic [15:0]      sat_count_o,
  input  logic             clr_count_i
);

  // The magnitude carries one bit more than the output. This lets the
  // negative limit 2^(OUT_W-1) be represented exactly. The extended shifter
  // adds room for the full 11-bit mantissa, so no set bit is lost before
  // the overflow test looks at it.
  localparam int MAG_W = OUT_W + 1;
  localparam int EXT_W = MAG_W + 11;

  // Pipeline occupancy and handshake state.
  logic s1Valid_q;
  logic outValid_q;
  logic s2Adv;
  logic s1Adv;

  // Stage 1 holds the decoded word.
  logic             s1Sign_q, s1Sign_d;
  logic [MAG_W-1:0] s1Mag_q,  s1Mag_d;
  logic             s1Ovf_q,  s1Ovf_d;
  logic             s1Inf_q,  s1Inf_d;
  logic             s1Nan_q,  s1Nan_d;

  // Stage 2 holds the final result.
  logic [OUT_W-1:0] outData_q, outData_d;
  logic             outSat_q,  outSat_d;

  logic [15:0] satCount_q, satCount_d;

  // Decode scratch signals.
  logic [4:0]       expField;
  logic [9:0]       fracField;
  logic [10:0]      mant;
  logic [4:0]       eEff;
  logic             isSpecial;
  int               shInt;
  logic [EXT_W-1:0] wide;

  // Signed limits used by the clamp stage.
  logic [MAG_W-1:0] negLimit;
  logic [MAG_W-1:0] posLimit;
  logic [OUT_W-1:0] maxPos;
  logic [OUT_W-1:0] minNeg;

  // Handshake: a stage may load whenever its own contents are leaving or it
  // is empty. in_ready depends only on out_ready and the stage valids, never
  // on in_valid, so no combinational path runs from in_valid to in_ready.
  always_comb begin
    s2Adv       = !outValid_q || out_ready_i;
    s1Adv       = !s1Valid_q || s2Adv;
    in_ready_o  = s1Adv;
    out_valid_o = outValid_q;
    out_data_o  = outData_q;
    out_sat_o   = outSat_q;
    sat_count_o = satCount_q;
  end

  // Stage 1 decode: build the mantissa with its hidden bit, then shift it to
  // the output LSB weight. sh = e_eff - 25 + FRAC_W, because the mantissa LSB
  // weighs 2^(e_eff-25). A left shift that would push set bits past the
  // magnitude width raises the overflow flag instead of wrapping. A right
  // shift of 11 or more clears every mantissa bit, so the magnitude is 0.
  always_comb begin
    expField  = in_data_i[14:10];
    fracField = in_data_i[9:0];
    isSpecial = (expField == 5'h1F);
    mant      = (expField == 5'd0) ? {1'b0, fracField} : {1'b1, fracField};
    eEff      = (expField == 5'd0) ? 5'd1 : expField;
    shInt     = int'(eEff) - 25 + FRAC_W;
    wide      = '0;
    s1Mag_d   = '0;
    s1Ovf_d   = 1'b0;
    s1Sign_d  = in_data_i[15];
    s1Inf_d   = isSpecial && (fracField == 10'd0);
    s1Nan_d   = isSpecial && (fracField != 10'd0);
    if (shInt >= 0) begin
      if (shInt > OUT_W) begin
        s1Ovf_d = (mant != 11'd0);
      end else begin
        wide    = EXT_W'(mant) << shInt;
        s1Ovf_d = |wide[EXT_W-1:MAG_W];
        s1Mag_d = wide[MAG_W-1:0];
      end
    end else if (-shInt < 11) begin
      s1Mag_d = MAG_W'(mant >> (-shInt));
    end
  end

  // Stage 2 sign and clamp. The negative range reaches one step further than
  // the positive range, so a magnitude of exactly 2^(OUT_W-1) is a legal
  // negative result. Any zero magnitude yields plain 0, so -0 is not flagged.
  always_comb begin
    negLimit  = MAG_W'(1) << (OUT_W - 1);
    posLimit  = negLimit - MAG_W'(1);
    maxPos    = {1'b0, {(OUT_W-1){1'b1}}};
    minNeg    = {1'b1, {(OUT_W-1){1'b0}}};
    outData_d = '0;
    outSat_d  = 1'b0;
    if (s1Nan_q) begin
      outSat_d = 1'b1;
    end else if (s1Inf_q) begin
      outSat_d  = 1'b1;
      outData_d = s1Sign_q ? minNeg : maxPos;
    end else if (s1Sign_q) begin
      if (s1Ovf_q || (s1Mag_q > negLimit)) begin
        outSat_d  = 1'b1;
        outData_d = minNeg;
      end else begin
        outData_d = OUT_W'(0) - s1Mag_q[OUT_W-1:0];
      end
    end else begin
      if (s1Ovf_q || (s1Mag_q > posLimit)) begin
        outSat_d  = 1'b1;
        outData_d = maxPos;
      end else begin
        outData_d = s1Mag_q[OUT_W-1:0];
      end
    end
  end

  // Saturation counter next state. A clear wins over a same-cycle increment.
  // The count sticks at all-ones rather than wrapping.
  always_comb begin
    satCount_d = satCount_q;
    if (clr_count_i) begin
      satCount_d = '0;
    end else if (outValid_q && out_ready_i && outSat_q && (satCount_q != 16'hFFFF)) begin
      satCount_d = satCount_q + 16'd1;
    end
  end

  // Pipeline registers. The valid bits move only when their stage advances.
  // Payload registers load only when a real word arrives, so a stalled
  // output keeps its data steady. Reset discards everything in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1Valid_q  <= 1'b0;
      outValid_q <= 1'b0;
      s1Sign_q   <= 1'b0;
      s1Mag_q    <= '0;
      s1Ovf_q    <= 1'b0;
      s1Inf_q    <= 1'b0;
      s1Nan_q    <= 1'b0;
      outData_q  <= '0;
      outSat_q   <= 1'b0;
      satCount_q <= '0;
    end else begin
      satCount_q <= satCount_d;
      if (s1Adv) begin
        s1Valid_q <= in_valid_i;
        if (in_valid_i) begin
          s1Sign_q <= s1Sign_d;
          s1Mag_q  <= s1Mag_d;
          s1Ovf_q  <= s1Ovf_d;
          s1Inf_q  <= s1Inf_d;
          s1Nan_q  <= s1Nan_d;
        end
      end
      if (s2Adv) begin
        outValid_q <= s1Valid_q;
        if (s1Valid_q) begin
          outData_q <= outData_d;
          outSat_q  <= outSat_d;
        end
      end
    end
  end

endmodule
